period_capture: RTL and testbench
=================================

# period_capture

Input-capture timer that measures the period of an external digital signal in `clk` cycles. It is the reading counterpart to the design's free-running counters: instead of generating a count, it consumes an asynchronous input and reports the count between successive rising edges. It sits between an FPGA input pin (tone, tachometer or sensor pulse) and the control logic, delivering a registered period word with a one-cycle valid strobe and a timeout flag when the input stalls.

## Interface
- `WIDTH`, 24: bit width of the cycle counter and the `period` output.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `en`  input  1  measurement enable, synchronous; 0 forces IDLE.
- `sig_in`  input  1  asynchronous signal under measurement.
- `period`  output  WIDTH  last captured period in `clk` cycles.
- `valid`  output  1  one-cycle strobe: `period` was updated this cycle.
- `timeout`  output  1  high while in the TIMEOUT state.
- `locked`  output  1  high while in the MEASURE state.

## Operation
- Synchronizer: two flops `s1`, `s2` on `sig_in`, plus history flop `s3` (`s3 <= s2`). `rise = s2 & ~s3` (combinational).
- Cycle counter `cnt`, WIDTH bits:
  - `cnt <= 1` on `rise`.
  - Otherwise `cnt <= cnt + 1`, saturating at all-ones.
- FSM states: IDLE, MEASURE, TIMEOUT.
  - IDLE: `cnt` held at 0. On `en & rise` → MEASURE with `cnt <= 1`; no capture.
  - MEASURE: on `rise`, `period <= cnt`, `valid <= 1`, `cnt <= 1`, stay. When `cnt == 2^WIDTH-1` and no `rise` → TIMEOUT.
  - TIMEOUT: `cnt` held. On `rise` → MEASURE with `cnt <= 1`; no capture, no valid.
  - Any state with `en == 0` → IDLE next cycle. `period` keeps its value; `valid` is 0.
- Precedence within one cycle: `reset` > `en == 0` > `rise` > saturation.
  - `rise` in the same cycle as `cnt == max` captures `period = 2^WIDTH-1` and stays in MEASURE; it does not time out.
- Registered outputs:
  - `valid` is registered and is 1 only in the cycle after a capturing edge.
  - `locked` and `timeout` are decodes of the state register.
- The measured value is the number of `clk` rising edges between two successive `rise` events. Resolution is ±1 cycle due to synchronization.
- Minimum measurable period is 2 cycles. Inputs faster than `clk/2` alias; this is not detected.

## Timing
- Reset values: `period = 0`, `valid = 0`, `timeout = 0`, `locked = 0`, state IDLE, `cnt = 0`, `s1 = s2 = s3 = 0`.
- Reset assertion takes effect immediately, mid-measurement included. Deassertion is followed by IDLE; the first rising edge after reset never produces `valid`.
- Latency: if `sig_in` is first sampled high at clock edge k, `rise` is true between edges k+1 and k+2. State, `cnt`, `period` and `valid` update at edge k+2. `valid` is high for exactly one cycle after k+2.
- Steady input of period N cycles (2 ≤ N ≤ 2^WIDTH-1):
  - The first edge after IDLE or TIMEOUT only arms the block.
  - Every following edge produces `valid` with `period = N`, spaced N cycles apart.
- Timeout: `2^WIDTH-1` cycles after the last `rise` with no new edge, `timeout` rises one cycle later. It clears at the edge that moves the FSM to MEASURE or IDLE.
- `en` falling: state becomes IDLE at the next edge. A `rise` in that same cycle is ignored.

## Test plan
- Reset: hold `reset = 0` with `sig_in` toggling → all outputs 0. Release, drive a 10-cycle square wave with `en = 1` → `locked` after the first edge, no `valid` for the first edge; every later edge gives `valid` with `period = 10`, strobes 10 cycles apart, 3-cycle latency from the input edge.
- Varying periods: edges spaced 7, 2, 33 cycles → `period` values 7, 2, 33 in order, one `valid` each.
- Timeout (`WIDTH = 8`): one edge, then hold low → `timeout = 1` and `locked = 0` 256 cycles after the `rise`. Next edge → `timeout = 0`, no `valid`; an edge 12 cycles later → `period = 12`.
- Boundary (`WIDTH = 8`): edges exactly 255 cycles apart → `period = 255`, `valid = 1`, `timeout` never asserts. At 256 apart → `timeout` asserts, and no `valid` is produced at that edge.
- `en` drop: deassert `en` mid-period → IDLE next cycle, `locked = 0`, `period` holds its last value. Re-enable → the first edge gives no `valid`, the second gives the correct period.
- Reset mid-measurement: assert `reset` 5 cycles after a capture → outputs immediately reset, `period = 0`. After release, normal re-arm behaviour is observed.

Source files
------------

// File: rtl/period_capture.sv
// Input-capture timer: measures the number of clk cycles between successive
// synchronized rising edges of sig_in, with a valid strobe and a stall timeout.
module period_capture #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             locked,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_cnt;
  logic             w_rise;

  // r_s3 only remembers the previous synchronized level for edge detection.
  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      period  <= '0;
      valid   <= 1'b0;
    end else begin
      r_s1  <= sig_in;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      valid <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_cnt   <= CNT_ONE;
            end else begin
              r_cnt <= '0;
            end
          end
          MEASURE: begin
            // An edge arriving with the counter saturated still captures.
            if (w_rise) begin
              period <= r_cnt;
              valid  <= 1'b1;
              r_cnt  <= CNT_ONE;
            end else if (r_cnt == CNT_MAX) begin
              r_state <= TIMEOUT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          TIMEOUT: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_cnt   <= CNT_ONE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign locked    = (r_state == MEASURE);
  assign timeout   = (r_state == TIMEOUT);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_period_capture.sv
// Bench for period_capture (WIDTH=8): table of edge gaps plus hand sequences
// for timeout, saturation boundary, enable drop and mid-measurement reset.
module tb_period_capture;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         en;
  logic         sig_in;
  logic [W-1:0] period;
  logic         valid;
  logic         timeout;
  logic         locked;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit saw_timeout = 1'b0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  period_capture #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .valid     (valid),
    .timeout   (timeout),
    .locked    (locked),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every valid strobe must match the oldest queued capture,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (timeout) saw_timeout = 1'b1;
    if (valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_valid: period=%0d at cycle %0d, none expected", period, cyc);
      end else begin
        logic [W-1:0] ep;
        int ec;
        ep = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("period", int'(period), int'(ep));
        chk("valid_cycle", cyc, ec);
      end
    end
  end

  // Raise sig_in at a negedge; a capturing edge is due 3 cycles later.
  task automatic drive_edge(input bit cap, input int exp_p);
    sig_in = 1'b1;
    if (cap) begin
      exp_q.push_back(W'(exp_p));
      exp_cyc_q.push_back(cyc + 3);
    end
  endtask

  task automatic send(input int gap, input bit cap, input int exp_p);
    drive_edge(cap, exp_p);
    repeat (gap / 2) @(negedge clk);
    sig_in = 1'b0;
    repeat (gap - gap / 2) @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int gap;
    bit cap;
    int exp_p;
    bit exp_locked;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{10, 1'b0, 0,  1'b1};
    vecs[1] = '{10, 1'b1, 10, 1'b1};
    vecs[2] = '{10, 1'b1, 10, 1'b1};
    vecs[3] = '{7,  1'b1, 10, 1'b1};
    vecs[4] = '{2,  1'b1, 7,  1'b1};
    vecs[5] = '{33, 1'b1, 2,  1'b1};
    vecs[6] = '{20, 1'b1, 33, 1'b1};
    vecs[7] = '{20, 1'b1, 20, 1'b1};

    reset  = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;

    // Reset held with sig_in toggling: everything stays cleared.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sig_in = ~sig_in;
    end
    @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_state", int'(state_dbg), 0);

    sig_in = 1'b0;
    reset  = 1'b1;
    en     = 1'b1;
    wait_n(4);
    chk("idle_after_rst", int'(state_dbg), 0);

    // Steady 10-cycle wave followed by gaps 7, 2, 33, 20.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].gap, vecs[i].cap, vecs[i].exp_p);
      chk("tbl_locked", int'(locked), int'(vecs[i].exp_locked));
      chk("tbl_timeout", int'(timeout), 0);
    end

    // Timeout: capture 20, then hold low until the counter saturates.
    drive_edge(1'b1, 20);
    wait_n(1);
    sig_in = 1'b0;
    wait_n(256);
    chk("to_before_timeout", int'(timeout), 0);
    chk("to_before_locked", int'(locked), 1);
    wait_n(1);
    chk("to_timeout", int'(timeout), 1);
    chk("to_locked", int'(locked), 0);
    chk("to_state", int'(state_dbg), 2);
    wait_n(5);

    // Edge out of TIMEOUT only re-arms; the next edge 12 later captures.
    drive_edge(1'b0, 0);
    wait_n(1);
    sig_in = 1'b0;
    wait_n(2);
    chk("rearm_timeout", int'(timeout), 0);
    chk("rearm_locked", int'(locked), 1);
    wait_n(9);
    drive_edge(1'b1, 12);
    wait_n(1);
    sig_in = 1'b0;

    // Boundary: edges exactly 255 apart capture 255 without timing out.
    wait_n(254);
    saw_timeout = 1'b0;
    drive_edge(1'b1, 255);
    wait_n(1);
    sig_in = 1'b0;
    wait_n(5);
    chk("b255_no_timeout", int'(saw_timeout), 0);
    chk("b255_locked", int'(locked), 1);

    // 256 apart: the block times out and the late edge only re-arms.
    wait_n(250);
    drive_edge(1'b0, 0);
    wait_n(1);
    sig_in = 1'b0;
    wait_n(5);
    chk("b256_saw_timeout", int'(saw_timeout), 1);
    chk("b256_locked", int'(locked), 1);

    // Enable drop mid-period: IDLE next cycle, period holds.
    wait_n(9);
    drive_edge(1'b1, 15);
    wait_n(1);
    sig_in = 1'b0;
    wait_n(5);
    en = 1'b0;
    wait_n(1);
    chk("en_locked", int'(locked), 0);
    chk("en_state", int'(state_dbg), 0);
    chk("en_period_hold", int'(period), 15);
    chk("en_valid", int'(valid), 0);
    wait_n(10);
    en = 1'b1;
    wait_n(2);
    send(9, 1'b0, 0);
    chk("reen_locked", int'(locked), 1);
    drive_edge(1'b1, 9);
    wait_n(1);
    sig_in = 1'b0;

    // Reset 5 cycles after the capture is reported clears outputs at once.
    wait_n(7);
    reset = 1'b0;
    #1;
    chk("midrst_period", int'(period), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_state", int'(state_dbg), 0);
    wait_n(3);
    reset = 1'b1;
    wait_n(3);
    send(8, 1'b0, 0);
    chk("post_rst_locked", int'(locked), 1);
    send(10, 1'b1, 8);
    wait_n(5);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
